// File: rtl/ysyx_22041207_mem_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, owner encoding and
// bus field widths.
package ysyx_22041207_mem_arbiter_pkg;

   localparam int unsigned AddrW = 64;
   localparam int unsigned DataW = 64;
   localparam int unsigned MaskW = 8;
   localparam int unsigned InstW = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StRsp  = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnIf   = 2'd1,
      OwnMem  = 2'd2
   } arb_owner_e;

   // Pick the 32-bit instruction out of a 64-bit beat using PC bit 2.
   function automatic logic [InstW-1:0] sel_inst(input logic [DataW-1:0] rdata,
                                                 input logic             hi);
      return hi ? rdata[63:32] : rdata[31:0];
   endfunction

endpackage

// File: rtl/ysyx_22041207_arb_grant.sv
// Combinational IF/MEM grant with MEM priority, plus the saturating counter that
// lets a waiting fetch through after STARVE_LIMIT back-to-back MEM grants.
module ysyx_22041207_arb_grant #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle_i,
   input  logic if_req_valid_i,
   input  logic if_flush_i,
   input  logic mem_req_valid_i,
   output logic grant_if_o,
   output logic grant_mem_o
);

   localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             if_live;
   logic             if_starved;

   always_comb begin
      if_live      = if_req_valid_i && !if_flush_i;
      if_starved   = if_live && (starve_cnt_q == Limit);
      grant_mem_o  = idle_i && mem_req_valid_i && !if_starved;
      grant_if_o   = idle_i && if_live && !grant_mem_o;
      starve_cnt_d = starve_cnt_q;
      // Raw if_req_valid counts as waiting, even if this cycle's fetch is being flushed.
      if (grant_if_o) begin
         starve_cnt_d = '0;
      end else if (grant_mem_o && if_req_valid_i && (starve_cnt_q != Limit)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// Shares the single 64-bit memory port between IF and MEM, one bus transaction at a
// time; stale (flushed) fetch responses are swallowed.
module ysyx_22041207_mem_arbiter
   import ysyx_22041207_mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req_valid,
   input  logic [AddrW-1:0] if_req_addr,
   output logic             if_req_ready,
   input  logic             if_flush,
   output logic             if_rsp_valid,
   output logic [InstW-1:0] if_rsp_inst,
   input  logic             mem_req_valid,
   input  logic [AddrW-1:0] mem_req_addr,
   input  logic             mem_req_wen,
   input  logic [DataW-1:0] mem_req_wdata,
   input  logic [MaskW-1:0] mem_req_wmask,
   output logic             mem_req_ready,
   output logic             mem_rsp_valid,
   output logic [DataW-1:0] mem_rsp_rdata,
   output logic             bus_req_valid,
   output logic [AddrW-1:0] bus_req_addr,
   output logic             bus_req_wen,
   output logic [DataW-1:0] bus_req_wdata,
   output logic [MaskW-1:0] bus_req_wmask,
   input  logic             bus_req_ready,
   input  logic             bus_rsp_valid,
   input  logic [DataW-1:0] bus_rsp_rdata
);

   arb_state_e       state_q, state_d;
   arb_owner_e       owner_q, owner_d;
   logic             drop_q, drop_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic             wen_q, wen_d;
   logic [DataW-1:0] wdata_q, wdata_d;
   logic [MaskW-1:0] wmask_q, wmask_d;
   logic             if_rsp_valid_q, if_rsp_valid_d;
   logic [InstW-1:0] if_rsp_inst_q, if_rsp_inst_d;
   logic             mem_rsp_valid_q, mem_rsp_valid_d;
   logic [DataW-1:0] mem_rsp_rdata_q, mem_rsp_rdata_d;

   logic idle;
   logic in_req;
   logic grant_if;
   logic grant_mem;

   // Gate with rst_n so no handshake is offered during the reset cycle.
   assign idle   = (state_q == StIdle) && rst_n;
   assign in_req = (state_q == StReq);

   ysyx_22041207_arb_grant #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_grant (
      .clk             (clk),
      .rst_n           (rst_n),
      .idle_i          (idle),
      .if_req_valid_i  (if_req_valid),
      .if_flush_i      (if_flush),
      .mem_req_valid_i (mem_req_valid),
      .grant_if_o      (grant_if),
      .grant_mem_o     (grant_mem)
   );

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      drop_d          = drop_q;
      addr_d          = addr_q;
      wen_d           = wen_q;
      wdata_d         = wdata_q;
      wmask_d         = wmask_q;
      if_rsp_valid_d  = 1'b0;
      if_rsp_inst_d   = '0;
      mem_rsp_valid_d = 1'b0;
      mem_rsp_rdata_d = '0;
      case (state_q)
         StIdle: begin
            if (grant_mem) begin
               state_d = StReq;
               owner_d = OwnMem;
               drop_d  = 1'b0;
               addr_d  = mem_req_addr;
               wen_d   = mem_req_wen;
               wdata_d = mem_req_wdata;
               wmask_d = mem_req_wmask;
            end else if (grant_if) begin
               state_d = StReq;
               owner_d = OwnIf;
               drop_d  = 1'b0;
               addr_d  = if_req_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
            end
         end
         StReq: begin
            if (owner_q == OwnIf && if_flush) drop_d = 1'b1;
            if (bus_req_ready) state_d = StRsp;
         end
         StRsp: begin
            if (owner_q == OwnIf && if_flush) drop_d = 1'b1;
            if (bus_rsp_valid) begin
               state_d = StIdle;
               owner_d = OwnNone;
               drop_d  = 1'b0;
               if (owner_q == OwnIf && !drop_q && !if_flush) begin
                  if_rsp_valid_d = 1'b1;
                  if_rsp_inst_d  = sel_inst(bus_rsp_rdata, addr_q[2]);
               end else if (owner_q == OwnMem) begin
                  mem_rsp_valid_d = 1'b1;
                  mem_rsp_rdata_d = wen_q ? '0 : bus_rsp_rdata;
               end
            end
         end
         default: begin
            state_d = StIdle;
            owner_d = OwnNone;
            drop_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         owner_q         <= OwnNone;
         drop_q          <= 1'b0;
         addr_q          <= '0;
         wen_q           <= 1'b0;
         wdata_q         <= '0;
         wmask_q         <= '0;
         if_rsp_valid_q  <= 1'b0;
         if_rsp_inst_q   <= '0;
         mem_rsp_valid_q <= 1'b0;
         mem_rsp_rdata_q <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         drop_q          <= drop_d;
         addr_q          <= addr_d;
         wen_q           <= wen_d;
         wdata_q         <= wdata_d;
         wmask_q         <= wmask_d;
         if_rsp_valid_q  <= if_rsp_valid_d;
         if_rsp_inst_q   <= if_rsp_inst_d;
         mem_rsp_valid_q <= mem_rsp_valid_d;
         mem_rsp_rdata_q <= mem_rsp_rdata_d;
      end
   end

   assign if_req_ready  = grant_if;
   assign mem_req_ready = grant_mem;
   assign if_rsp_valid  = if_rsp_valid_q;
   assign if_rsp_inst   = if_rsp_inst_q;
   assign mem_rsp_valid = mem_rsp_valid_q;
   assign mem_rsp_rdata = mem_rsp_rdata_q;
   assign bus_req_valid = in_req;
   assign bus_req_addr  = in_req ? addr_q : '0;
   assign bus_req_wen   = in_req && wen_q;
   assign bus_req_wdata = in_req ? wdata_q : '0;
   assign bus_req_wmask = in_req ? wmask_q : '0;

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Bench for the IF/MEM arbiter: table of single transactions against a stallable bus
// model, plus hand-written priority, starvation, flush and reset sequences.
module tb_ysyx_22041207_mem_arbiter;

   localparam int KIf    = 0;
   localparam int KLoad  = 1;
   localparam int KStore = 2;

   logic        clk, rst_n;
   logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
   logic [63:0] if_req_addr;
   logic [31:0] if_rsp_inst;
   logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_rsp_valid;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
   logic [7:0]  mem_req_wmask;
   logic        bus_req_valid, bus_req_wen, bus_req_ready, bus_rsp_valid;
   logic [63:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
   logic [7:0]  bus_req_wmask;

   ysyx_22041207_mem_arbiter #(
      .STARVE_LIMIT (4),
      .CNT_W        (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_req_ready  (if_req_ready),
      .if_flush      (if_flush),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_inst   (if_rsp_inst),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wen   (mem_req_wen),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wmask (mem_req_wmask),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .bus_req_valid (bus_req_valid),
      .bus_req_addr  (bus_req_addr),
      .bus_req_wen   (bus_req_wen),
      .bus_req_wdata (bus_req_wdata),
      .bus_req_wmask (bus_req_wmask),
      .bus_req_ready (bus_req_ready),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata)
   );

   typedef struct {
      int          kind;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] rdata;
      int          rdly;
      int          sdly;
      logic [63:0] exp_data;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        if_q[$];
   exp_t        mem_q[$];
   exp_t        mon_e;
   vec_t        vecs[6];
   int          n_vec, n_err, cyc, if_cnt, mem_cnt;
   logic [63:0] bus_data;
   int          bus_rdly, bus_sdly;
   logic [63:0] lg_addr, lg_wdata;
   logic        lg_wen;
   logic [7:0]  lg_wmask;
   bit          bm_pend;
   int          bm_wait, bm_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Bus model: ready after bus_rdly cycles of valid, response bus_sdly cycles after accept.
   initial begin
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = '0;
      bm_pend       = 1'b0;
      bm_wait       = 0;
      bm_stall      = 0;
      forever begin
         @(negedge clk);
         #1;
         bus_rsp_valid = 1'b0;
         bus_rsp_rdata = '0;
         if (rst_n !== 1'b1) begin
            bus_req_ready = 1'b0;
            bm_pend       = 1'b0;
            bm_stall      = 0;
         end else begin
            if (bus_req_ready) begin
               bm_pend  = 1'b1;
               bm_wait  = bus_sdly;
               bm_stall = 0;
            end
            bus_req_ready = 1'b0;
            if (bm_pend) begin
               if (bm_wait == 0) begin
                  bus_rsp_valid = 1'b1;
                  bus_rsp_rdata = bus_data;
                  bm_pend       = 1'b0;
               end else begin
                  bm_wait--;
               end
            end else if (bus_req_valid) begin
               if (bm_stall >= bus_rdly) begin
                  bus_req_ready = 1'b1;
                  lg_addr       = bus_req_addr;
                  lg_wen        = bus_req_wen;
                  lg_wdata      = bus_req_wdata;
                  lg_wmask      = bus_req_wmask;
               end else begin
                  bm_stall++;
               end
            end
         end
      end
   end

   // Scoreboard monitor: every response pulse must match the oldest expectation.
   initial begin
      if_cnt  = 0;
      mem_cnt = 0;
      forever begin
         @(negedge clk);
         #2;
         if (if_rsp_valid === 1'b1) begin
            if_cnt++;
            if (if_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL if_rsp_unexpected: got pulse inst %h, expected none (cycle %0d)",
                        if_rsp_inst, cyc);
            end else begin
               mon_e = if_q.pop_front();
               check("if_rsp_inst", 64'(if_rsp_inst), mon_e.data);
               check("if_rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
         end
         if (mem_rsp_valid === 1'b1) begin
            mem_cnt++;
            if (mem_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL mem_rsp_unexpected: got pulse rdata %h, expected none (cycle %0d)",
                        mem_rsp_rdata, cyc);
            end else begin
               mon_e = mem_q.pop_front();
               check("mem_rsp_rdata", mem_rsp_rdata, mon_e.data);
               check("mem_rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
         end
      end
   end

   task automatic idle_inputs();
      if_req_valid  = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '1;
      mem_req_wmask = '1;
   endtask

   task automatic issue(input int kind, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic [63:0] exp_data,
                        input int lat_extra, input bit push,
                        output int start_c, output int acc_c);
      exp_t e;
      @(negedge clk);
      if (kind == KIf) begin
         if_req_valid = 1'b1;
         if_req_addr  = addr;
      end else begin
         mem_req_valid = 1'b1;
         mem_req_addr  = addr;
         mem_req_wen   = (kind == KStore);
         mem_req_wdata = wdata;
         mem_req_wmask = wmask;
      end
      start_c = cyc;
      acc_c   = -1;
      for (int i = 0; i < 40; i++) begin
         #3;
         if ((kind == KIf) ? if_req_ready : mem_req_ready) begin
            acc_c = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc_c < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL req_ready_timeout: got no ready in 40 cycles, expected a grant");
      end else if (push) begin
         e.data = exp_data;
         e.due  = acc_c + 3 + lat_extra;
         if (kind == KIf) if_q.push_back(e);
         else mem_q.push_back(e);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && (if_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
      if (if_q.size() != 0 || mem_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d IF / %0d MEM responses outstanding, expected 0",
                  if_q.size(), mem_q.size());
         if_q.delete();
         mem_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int   s_c, a_c, m_acc, i_acc, cnt0, grants;
      bit   got_if[10];
      exp_t e;

      vecs[0] = '{KIf,    64'h8000_0004, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 0,
                  64'h1111_2222};
      vecs[1] = '{KIf,    64'h8000_0000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 0,
                  64'h3333_4444};
      vecs[2] = '{KLoad,  64'h8000_0010, 64'h0, 8'h00, 64'hCAFE_BABE_0123_4567, 2, 1,
                  64'hCAFE_BABE_0123_4567};
      vecs[3] = '{KStore, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h5555_5555_5555_5555, 0, 0,
                  64'h0};
      vecs[4] = '{KIf,    64'h8000_000C, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 1, 2,
                  64'hAAAA_BBBB};
      vecs[5] = '{KLoad,  64'h8000_2008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 3, 0,
                  64'h0123_4567_89AB_CDEF};

      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      if_flush    = 1'b0;
      if_req_addr = '0;
      mem_req_addr = '0;
      bus_data    = '0;
      bus_rdly    = 0;
      bus_sdly    = 0;
      idle_inputs();
      repeat (3) @(negedge clk);
      #3;
      check("reset_ctrl", {if_req_ready, if_rsp_valid, mem_req_ready, mem_rsp_valid,
                           bus_req_valid, bus_req_wen, bus_req_wmask}, 64'h0);
      check("reset_bus_addr", bus_req_addr, 64'h0);
      check("reset_rsp_data", mem_rsp_rdata | 64'(if_rsp_inst), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single transactions, including the lone-fetch and store cases.
      foreach (vecs[v]) begin
         bus_data = vecs[v].rdata;
         bus_rdly = vecs[v].rdly;
         bus_sdly = vecs[v].sdly;
         lg_addr  = 64'hX;
         issue(vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].exp_data,
               vecs[v].rdly + vecs[v].sdly, 1'b1, s_c, a_c);
         check("grant_no_wait", 64'(a_c), 64'(s_c));
         wait_drain();
         check("bus_addr", lg_addr, vecs[v].addr);
         check("bus_wen", 64'(lg_wen), 64'(vecs[v].kind == KStore));
         check("bus_wdata", lg_wdata, vecs[v].wdata);
         check("bus_wmask", 64'(lg_wmask), 64'(vecs[v].wmask));
      end

      // IF and MEM together: MEM first, IF granted at the next IDLE.
      bus_data = 64'h7777_8888_9999_AAAA;
      bus_rdly = 0;
      bus_sdly = 0;
      @(negedge clk);
      if_req_valid  = 1'b1;
      if_req_addr   = 64'h8000_0008;
      mem_req_valid = 1'b1;
      mem_req_addr  = 64'h8000_0020;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      #3;
      check("both_mem_ready", 64'(mem_req_ready), 64'h1);
      check("both_if_ready", 64'(if_req_ready), 64'h0);
      m_acc  = cyc;
      e.data = bus_data;
      e.due  = m_acc + 3;
      mem_q.push_back(e);
      @(negedge clk);
      mem_req_valid = 1'b0;
      i_acc = -1;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (if_req_ready) begin
            i_acc = cyc;
            break;
         end
         @(negedge clk);
      end
      check("both_if_grant_cycle", 64'(i_acc), 64'(m_acc + 3));
      e.data = 64'(bus_data[31:0]);
      e.due  = i_acc + 3;
      if_q.push_back(e);
      @(negedge clk);
      idle_inputs();
      wait_drain();

      // Starvation guard: MEM held valid with IF waiting -> 4 MEM grants, then IF.
      bus_data = 64'h0BAD_F00D_1234_5678;
      @(negedge clk);
      if_req_valid  = 1'b1;
      if_req_addr   = 64'h8000_0100;
      mem_req_valid = 1'b1;
      mem_req_addr  = 64'h8000_0200;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      grants = 0;
      for (int i = 0; i < 200 && grants < 10; i++) begin
         #3;
         if (mem_req_ready || if_req_ready) begin
            got_if[grants] = if_req_ready;
            e.due  = cyc + 3;
            e.data = if_req_ready ? 64'(bus_data[31:0]) : bus_data;
            if (if_req_ready) if_q.push_back(e);
            else mem_q.push_back(e);
            grants++;
         end
         @(negedge clk);
      end
      idle_inputs();
      check("starve_grant_count", 64'(grants), 64'd10);
      for (int g = 0; g < grants; g++) begin
         check("starve_grant_order", 64'(got_if[g]), 64'(g == 4 || g == 9));
      end
      wait_drain();

      // Flush in IDLE suppresses the IF grant.
      @(negedge clk);
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0300;
      if_flush     = 1'b1;
      #3;
      check("flush_idle_if_ready", 64'(if_req_ready), 64'h0);
      @(negedge clk);
      if_flush = 1'b0;
      idle_inputs();

      // Flush while a fetch is in RSP: late response and same-cycle response both dropped.
      for (int k = 0; k < 2; k++) begin
         bus_data = 64'h4444_3333_2222_1111;
         bus_rdly = 0;
         bus_sdly = (k == 0) ? 2 : 0;
         cnt0     = if_cnt;
         issue(KIf, 64'h8000_0400, 64'h0, 8'h00, 64'h0, 0, 1'b0, s_c, a_c);
         @(negedge clk);
         if_flush = 1'b1;
         @(negedge clk);
         if_flush = 1'b0;
         repeat (8) @(negedge clk);
         check("flush_no_if_rsp", 64'(if_cnt), 64'(cnt0));
         bus_sdly = 0;
         issue(KIf, 64'h8000_0404, 64'h0, 8'h00, 64'h4444_3333, 0, 1'b1, s_c, a_c);
         check("flush_next_grant", 64'(a_c), 64'(s_c));
         wait_drain();
      end

      // Reset while the bus stalls ready in REQ: transaction abandoned, no pulse.
      bus_data = 64'hFEED_FACE_CAFE_D00D;
      bus_rdly = 3;
      bus_sdly = 0;
      cnt0     = mem_cnt;
      issue(KLoad, 64'h8000_0500, 64'h0, 8'h00, 64'h0, 0, 1'b0, s_c, a_c);
      rst_n = 1'b0;
      @(negedge clk);
      #3;
      check("midrst_ctrl", {if_req_ready, if_rsp_valid, mem_req_ready, mem_rsp_valid,
                            bus_req_valid, bus_req_wen, bus_req_wmask}, 64'h0);
      check("midrst_bus_addr", bus_req_addr | bus_req_wdata, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_no_mem_rsp", 64'(mem_cnt), 64'(cnt0));
      bus_rdly = 0;
      issue(KLoad, 64'h8000_0508, 64'h0, 8'h00, bus_data, 0, 1'b1, s_c, a_c);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected $finish before 200000");
      $fatal(1);
   end

endmodule
